// File: rtl/beam_steer_sequencer.sv
// Steering-delay sequencer: sweeps the mic grid, reads ROM delays and
// writes clipped tap indices into the shadow delay file, then commits.
module beam_steer_sequencer #(
   parameter int NUM_ROWS  = 5,
   parameter int NUM_COLS  = 5,
   parameter int TAP_SHIFT = 3,
   parameter int TAP_MAX   = 31
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] angle_hori,
   input  logic [7:0] angle_vert,
   output logic       rom_rd_en,
   output logic [8:0] rom_addr_hori,
   output logic [8:0] rom_addr_vert,
   input  logic [7:0] rom_q_hori,
   input  logic [7:0] rom_q_vert,
   output logic       dly_wr_en,
   output logic [4:0] dly_wr_idx,
   output logic [4:0] dly_wr_data,
   output logic       commit,
   output logic       busy,
   output logic       done,
   output logic       sat_flag
);

   localparam int N = NUM_ROWS * NUM_COLS;
   localparam logic [2:0] LAST_COL = 3'(NUM_COLS - 1);
   localparam logic [2:0] LAST_ROW = 3'(NUM_ROWS - 1);
   localparam logic [4:0] LAST_MIC = 5'(N - 1);

   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, COMMIT} state_t;

   state_t     state, state_d;
   logic [2:0] row, row_d, col, col_d;
   logic [4:0] mic, mic_d;
   logic [7:0] ang_h, ang_h_d, ang_v, ang_v_d;
   logic       ready_q, rd_d, sat_d;
   logic [8:0] addr_h_d, addr_v_d;
   logic [8:0] sum, tap;
   logic       tap_ovf;

   // Negative angles mirror the grid position so the wavefront runs backwards.
   function automatic logic [8:0] form_addr(input logic [7:0] ang,
                                            input logic [2:0] pos,
                                            input logic [2:0] last);
      logic [7:0] mag;
      logic [5:0] a;
      logic [2:0] p;
      mag = ang[7] ? (~ang + 8'd1) : ang;
      a   = (mag > 8'd63) ? 6'd63 : mag[5:0];
      p   = ang[7] ? (last - pos) : pos;
      return {p, a};
   endfunction

   assign req_ready = ready_q & ~rst;

   // ROM data arrives with the write slot, so the tap is formed from it here.
   assign sum     = {1'b0, rom_q_hori} + {1'b0, rom_q_vert};
   assign tap     = sum >> TAP_SHIFT;
   assign tap_ovf = tap > 9'(TAP_MAX);
   assign dly_wr_data = !dly_wr_en ? 5'd0 :
                        tap_ovf    ? 5'(TAP_MAX) : tap[4:0];

   always_comb begin
      state_d  = state;
      row_d    = row;
      col_d    = col;
      mic_d    = mic;
      ang_h_d  = ang_h;
      ang_v_d  = ang_v;
      rd_d     = 1'b0;
      addr_h_d = '0;
      addr_v_d = '0;
      sat_d    = sat_flag | (dly_wr_en & tap_ovf);
      unique case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               state_d  = SWEEP;
               ang_h_d  = angle_hori;
               ang_v_d  = angle_vert;
               row_d    = '0;
               col_d    = '0;
               mic_d    = '0;
               sat_d    = 1'b0;
               rd_d     = 1'b1;
               addr_h_d = form_addr(angle_hori, 3'd0, LAST_COL);
               addr_v_d = form_addr(angle_vert, 3'd0, LAST_ROW);
            end
         end
         SWEEP: begin
            if (mic == LAST_MIC) begin
               state_d = DRAIN;
            end else begin
               mic_d = mic + 5'd1;
               if (col == LAST_COL) begin
                  col_d = '0;
                  row_d = row + 3'd1;
               end else begin
                  col_d = col + 3'd1;
               end
               rd_d     = 1'b1;
               addr_h_d = form_addr(ang_h, col_d, LAST_COL);
               addr_v_d = form_addr(ang_v, row_d, LAST_ROW);
            end
         end
         DRAIN:   state_d = COMMIT;
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         row           <= '0;
         col           <= '0;
         mic           <= '0;
         ang_h         <= '0;
         ang_v         <= '0;
         ready_q       <= 1'b1;
         busy          <= 1'b0;
         rom_rd_en     <= 1'b0;
         rom_addr_hori <= '0;
         rom_addr_vert <= '0;
         dly_wr_en     <= 1'b0;
         dly_wr_idx    <= '0;
         commit        <= 1'b0;
         done          <= 1'b0;
         sat_flag      <= 1'b0;
      end else begin
         state         <= state_d;
         row           <= row_d;
         col           <= col_d;
         mic           <= mic_d;
         ang_h         <= ang_h_d;
         ang_v         <= ang_v_d;
         ready_q       <= (state_d == IDLE);
         busy          <= (state_d != IDLE);
         rom_rd_en     <= rd_d;
         rom_addr_hori <= addr_h_d;
         rom_addr_vert <= addr_v_d;
         dly_wr_en     <= rom_rd_en;
         dly_wr_idx    <= rom_rd_en ? mic : 5'd0;
         commit        <= (state_d == COMMIT);
         done          <= (state_d == COMMIT);
         sat_flag      <= sat_d;
      end
   end

endmodule

// File: tb/tb_beam_steer_sequencer.sv
// Randomized bench for beam_steer_sequencer against a cycle-offset model
// derived from the accept time, angles and ROM contents.
module tb_beam_steer_sequencer;

   localparam int NR = 5;
   localparam int NC = 5;
   localparam int N  = NR * NC;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [7:0] angle_hori = '0;
   logic [7:0] angle_vert = '0;
   logic       rom_rd_en;
   logic [8:0] rom_addr_hori, rom_addr_vert;
   logic [7:0] rom_q_hori = '0;
   logic [7:0] rom_q_vert = '0;
   logic       dly_wr_en;
   logic [4:0] dly_wr_idx, dly_wr_data;
   logic       commit, busy, done, sat_flag;

   int rom_mode = 0;
   int n_chk = 0;
   int n_err = 0;
   int m_k = 0;
   bit m_ready = 1'b1;
   bit m_sat = 1'b0;
   bit prev_rst = 1'b1;
   int m_ah = 0, m_av = 0, m_mode = 0;
   int n_acc = 0;
   int dut_commits = 0;
   bit lit_en = 1'b0;
   int lit_ah0, lit_av0, lit_last, lit_sat;

   always #5 clk = ~clk;

   beam_steer_sequencer dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .angle_hori(angle_hori), .angle_vert(angle_vert),
      .rom_rd_en(rom_rd_en),
      .rom_addr_hori(rom_addr_hori), .rom_addr_vert(rom_addr_vert),
      .rom_q_hori(rom_q_hori), .rom_q_vert(rom_q_vert),
      .dly_wr_en(dly_wr_en), .dly_wr_idx(dly_wr_idx),
      .dly_wr_data(dly_wr_data),
      .commit(commit), .busy(busy), .done(done), .sat_flag(sat_flag)
   );

   function automatic int rom_f(input int mode, input int addr);
      case (mode)
         0:       return (addr / 64) * 8 + addr % 64;
         1:       return 200;
         default: return (addr * 73 + 19) % 256;
      endcase
   endfunction

   function automatic int ax_addr(input int ang, input int pos, input int npos);
      int a, p;
      a = (ang < 0) ? -ang : ang;
      if (a > 63) a = 63;
      p = (ang < 0) ? (npos - 1 - pos) : pos;
      return p * 64 + a;
   endfunction

   function automatic int raw_tap(input int mode, input int ah, input int av,
                                  input int m);
      int s;
      s = rom_f(mode, ax_addr(ah, m % NC, NC)) + rom_f(mode, ax_addr(av, m / NC, NR));
      return s >> 3;
   endfunction

   always @(posedge clk) begin
      rom_q_hori <= 8'(rom_f(rom_mode, int'(rom_addr_hori)));
      rom_q_vert <= 8'(rom_f(rom_mode, int'(rom_addr_vert)));
   end

   task automatic chk(input string nm, input logic [31:0] act, input int exp);
      n_chk++;
      if (act !== 32'(exp)) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      int m, t;
      bit rd, wr;
      rd = (m_k >= 1) && (m_k <= N);
      wr = (m_k >= 2) && (m_k <= N + 1);
      if (commit === 1'b1) dut_commits++;
      chk("req_ready", req_ready, int'(m_ready && !rst));
      chk("busy", busy, int'(m_k >= 1));
      chk("rom_rd_en", rom_rd_en, int'(rd));
      chk("dly_wr_en", dly_wr_en, int'(wr));
      chk("commit", commit, int'(m_k == N + 2));
      chk("done", done, int'(m_k == N + 2));
      chk("sat_flag", sat_flag, int'(m_sat));
      if (rd) begin
         m = m_k - 1;
         chk("rom_addr_hori", rom_addr_hori, ax_addr(m_ah, m % NC, NC));
         chk("rom_addr_vert", rom_addr_vert, ax_addr(m_av, m / NC, NR));
      end
      if (wr) begin
         m = m_k - 2;
         t = raw_tap(m_mode, m_ah, m_av, m);
         chk("dly_wr_idx", dly_wr_idx, m);
         chk("dly_wr_data", dly_wr_data, (t > 31) ? 31 : t);
      end
      if (prev_rst) begin
         chk("rst_addr_hori", rom_addr_hori, 0);
         chk("rst_addr_vert", rom_addr_vert, 0);
         chk("rst_wr_idx", dly_wr_idx, 0);
         chk("rst_wr_data", dly_wr_data, 0);
      end
      if (lit_en && m_k == 1) begin
         chk("lit_addr_hori_mic0", rom_addr_hori, lit_ah0);
         chk("lit_addr_vert_mic0", rom_addr_vert, lit_av0);
      end
      if (lit_en && m_k == N + 1)
         chk("lit_last_data", dly_wr_data, lit_last);
      if (lit_en && m_k == N + 2) begin
         chk("lit_commit", commit, 1);
         chk("lit_sat", sat_flag, lit_sat);
         lit_en = 1'b0;
      end
      if (rst) begin
         m_k = 0;
         m_ready = 1'b1;
         m_sat = 1'b0;
      end else if (m_ready && req_valid) begin
         m_k = 1;
         m_ready = 1'b0;
         m_sat = 1'b0;
         m_ah = int'($signed(angle_hori));
         m_av = int'($signed(angle_vert));
         m_mode = rom_mode;
         n_acc++;
      end else if (m_k >= 1) begin
         if (wr && raw_tap(m_mode, m_ah, m_av, m_k - 2) > 31) m_sat = 1'b1;
         if (m_k == N + 2) begin
            m_k = 0;
            m_ready = 1'b1;
         end else begin
            m_k++;
         end
      end
      prev_rst = rst;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic request(input int ah, input int av, input int mode);
      int start, guard;
      angle_hori = 8'(ah);
      angle_vert = 8'(av);
      rom_mode = mode;
      start = n_acc;
      req_valid = 1'b1;
      guard = 0;
      while (n_acc == start && guard < 200) begin
         @(negedge clk);
         #1;
         guard++;
      end
      chk("accept", n_acc, start + 1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      while (m_k != 0 && g < 200) begin
         cyc(1);
         g++;
      end
      chk("sweep_end", m_k, 0);
   endtask

   task automatic lit(input int ah0, input int av0, input int last, input int sat);
      lit_ah0 = ah0;
      lit_av0 = av0;
      lit_last = last;
      lit_sat = sat;
      lit_en = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1);
   end

   initial begin
      int c0;
      cyc(3);
      rst = 1'b0;
      cyc(4);
      rst = 1'b1;
      cyc(3);
      rst = 1'b0;
      cyc(2);

      lit(0, 0, 8, 0);
      request(0, 0, 0);
      wait_idle();
      lit(261, 0, 4, 0);
      request(-5, 0, 0);
      wait_idle();
      lit(5, 319, 12, 0);
      request(5, -128, 0);
      wait_idle();
      cyc(2);
      lit(0, 0, 31, 1);
      request(0, 0, 1);
      wait_idle();
      cyc(3);
      request(17, -40, 2);
      wait_idle();

      c0 = dut_commits;
      angle_hori = 8'($urandom_range(0, 255));
      angle_vert = 8'($urandom_range(0, 255));
      rom_mode = 2;
      begin
         int start, g;
         start = n_acc;
         g = 0;
         req_valid = 1'b1;
         while (n_acc < start + 3 && g < 300) begin
            cyc(1);
            g++;
         end
         req_valid = 1'b0;
         chk("b2b_accepts", n_acc, start + 3);
      end
      wait_idle();
      cyc(1);
      chk("b2b_commits", dut_commits - c0, 3);

      c0 = dut_commits;
      request(-90, 33, 2);
      cyc(9);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      cyc(N + 5);
      chk("abort_no_commit", dut_commits - c0, 0);
      lit(0, 0, 8, 0);
      request(0, 0, 0);
      wait_idle();

      for (int i = 0; i < 16; i++) begin
         cyc($urandom_range(0, 3));
         request($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
                 $urandom_range(0, 2));
         wait_idle();
      end
      cyc(3);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
